// File: rtl/psi_bitmask_decoder.sv
// -----------------------------------------------------------------------------
// psi_bitmask_decoder
//
// Takes a B-bit set bitmask and emits the index of each member, lowest first,
// one index per out handshake. A one-cycle 'done' pulse closes each set,
// including the empty set.
//
// Optional feature (compile-time macro): PSI_DEC_COUNT_EN
//   defined   -> port 'cnt' reports the members emitted for the current set
//   undefined -> no 'cnt' port and no counter
//
// Ports
//   clk        single clock, rising-edge state updates
//   rst        synchronous, active-high reset
//   in_valid   bitmask offered
//   in_ready   decoder accepts a bitmask this cycle (IDLE only)
//   in_mask    B-bit bitmask, bit i set means element i is in the set
//   out_valid  out_idx holds a member index
//   out_ready  consumer accepts out_idx
//   out_idx    index of the current member
//   out_last   current index is the final member of the set
//   done       one-cycle pulse when emission of a set completes
//   cnt        members emitted for the current set (PSI_DEC_COUNT_EN only)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its payload stable until ready; here
// out_idx/out_last depend only on registered state, so they cannot change
// while out_valid is high and out_ready is low.
// -----------------------------------------------------------------------------
module psi_bitmask_decoder #(
  parameter int B  = 10,
  parameter int IW = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [B-1:0]  in_mask,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          done
`ifdef PSI_DEC_COUNT_EN
  ,
  output logic [CW-1:0] cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t       state;
  logic [B-1:0] rem;

  // rem with its lowest set bit cleared
  logic [B-1:0] rem_next;
  assign rem_next = rem & (rem - B'(1));

  // All outputs are decoded from registered state and rem only.
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_SCAN);
  assign done      = (state == ST_DONE);
  // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
  assign out_last  = (rem != '0) && (rem_next == '0);

  // Priority encoder: descending scan so the lowest set bit wins.
  always_comb begin
    out_idx = '0;
    for (int i = B - 1; i >= 0; i--) begin
      if (rem[i]) out_idx = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      rem   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            rem   <= in_mask;
            state <= (in_mask != '0) ? ST_SCAN : ST_DONE;
          end
        end
        ST_SCAN: begin
          // in_valid is not looked at here, so offers during SCAN are dropped
          if (out_ready) begin
            rem <= rem_next;
            if (out_last) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PSI_DEC_COUNT_EN
  // Cleared on load, counts out handshakes, held until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ST_IDLE && in_valid) begin
      cnt <= '0;
    end else if (state == ST_SCAN && out_ready) begin
      cnt <= cnt + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_psi_bitmask_decoder.sv
// -----------------------------------------------------------------------------
// tb_psi_bitmask_decoder
//
// Self-checking bench for psi_bitmask_decoder (default parameters, B=10).
// Directed vector table, hand-written reset/stall sequences and random sets
// checked against a member-list reference model. 'cnt' is checked only when
// PSI_DEC_COUNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_psi_bitmask_decoder;

  localparam int B  = 10;
  localparam int IW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [B-1:0]  in_mask;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          done;
`ifdef PSI_DEC_COUNT_EN
  logic [CW-1:0] cnt;
`endif

  psi_bitmask_decoder #(.B(B), .IW(IW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done)
`ifdef PSI_DEC_COUNT_EN
    ,
    .cnt       (cnt)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [IW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: act=%0d exp=%0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the members of the set, ascending.
  task automatic model_load(input logic [B-1:0] mask);
    exp_q.delete();
    for (int i = 0; i < B; i++) begin
      if (mask[i]) exp_q.push_back(IW'(i));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_mask = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Load one set and consume it. Called and returning at a negedge.
  // stall_pct: chance (0..100) that out_ready is low in a SCAN cycle.
  // inject: offer random bitmasks on in_valid during SCAN.
  task automatic run_set(input logic [B-1:0] mask, input int stall_pct, input bit inject,
                         output int n_emit, output int first_idx);
    int   cyc;
    bit   got_done;
    bit   prev_stall;
    logic [IW-1:0] prev_idx;
    model_load(mask);
    n_emit = 0; first_idx = -1; prev_stall = 0; prev_idx = '0;
    check("load_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_mask = mask; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0; got_done = 0;
    while (!got_done && cyc < 100) begin
      if (cyc == 0) begin
        check("first_out_valid", 32'(out_valid), 32'(mask != '0));
        check("first_done", 32'(done), 32'(mask == '0));
      end
      if (out_valid) begin
        check("scan_in_ready", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          check("extra_index", 32'(out_idx), 32'hFFFF);
        end else begin
          check("out_idx", 32'(out_idx), 32'(exp_q[0]));
          check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
        end
        if (prev_stall) check("stall_stable", 32'(out_idx), 32'(prev_idx));
        if (first_idx < 0) first_idx = int'(out_idx);
        out_ready = ($urandom_range(0, 99) >= stall_pct);
        prev_stall = !out_ready;
        prev_idx = out_idx;
        if (out_ready) begin
          n_emit++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        in_valid = inject ? 1'($urandom_range(0, 1)) : 1'b0;
        in_mask  = B'($urandom_range(0, (1 << B) - 1));
      end else if (done) begin
        check("done_all_emitted", 32'(exp_q.size()), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd0);
`ifdef PSI_DEC_COUNT_EN
        check("done_cnt", 32'(cnt), 32'(n_emit));
`endif
        got_done = 1; in_valid = 1'b0; out_ready = 1'b0;
      end else begin
        check("unexpected_idle", 32'(in_ready), 32'd0);
        got_done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    if (!got_done) check("done_timeout", 32'(cyc), 32'd0);
    in_valid = 1'b0;
    check("post_done_in_ready", 32'(in_ready), 32'd1);
    check("post_done_no_done", 32'(done), 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [B-1:0] mask;
    int           stall_pct;
    bit           inject;
    int           exp_n;
    int           exp_first;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n_emit, first_idx, cyc;
    vecs[0] = '{10'b0000000101, 0,  1'b0, 2,  0};
    vecs[1] = '{10'h000,        0,  1'b0, 0,  -1};
    vecs[2] = '{10'h3FF,        0,  1'b0, 10, 0};
    vecs[3] = '{10'b1000010000, 50, 1'b0, 2,  4};
    vecs[4] = '{10'h200,        0,  1'b0, 1,  9};
    vecs[5] = '{10'h2AA,        30, 1'b1, 5,  1};
    vecs[6] = '{10'h180,        0,  1'b1, 2,  7};

    do_reset();
    // reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
`ifdef PSI_DEC_COUNT_EN
    check("rst_cnt", 32'(cnt), 32'd0);
`endif

    for (int v = 0; v < 7; v++) begin
      run_set(vecs[v].mask, vecs[v].stall_pct, vecs[v].inject, n_emit, first_idx);
      check("vec_count", 32'(n_emit), 32'(vecs[v].exp_n));
      check("vec_first", 32'(first_idx), 32'(vecs[v].exp_first));
    end

    // out_ready low for 3 cycles: index 4 must hold, then 4 and 9 (last).
    in_valid = 1'b1; in_mask = 10'b1000010000; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_idx", 32'(out_idx), 32'd4);
      check("hold_last", 32'(out_last), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("hold_idx_go", 32'(out_idx), 32'd4);
    @(negedge clk);
    check("hold_idx9", 32'(out_idx), 32'd9);
    check("hold_last9", 32'(out_last), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_done", 32'(done), 32'd1);
    @(negedge clk);

    // reset after the first handshake of a full set discards it
    in_valid = 1'b1; in_mask = 10'h3FF; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstmid_first_idx", 32'(out_idx), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd1);
    check("rstmid_out_idx", 32'(out_idx), 32'd0);
    cyc = 0;
    for (int k = 0; k < 5; k++) begin
      if (done || out_valid) cyc++;
      @(negedge clk);
    end
    check("rstmid_no_activity", 32'(cyc), 32'd0);
    out_ready = 1'b0;

    // random sets with random stalls and stray in_valid offers
    for (int r = 0; r < 40; r++) begin
      logic [B-1:0] m;
      int exp_n;
      m = B'($urandom_range(0, (1 << B) - 1));
      if ($urandom_range(0, 7) == 0) m = '0;
      exp_n = $countones(m);
      run_set(m, $urandom_range(0, 60), 1'($urandom_range(0, 1)), n_emit, first_idx);
      check("rand_count", 32'(n_emit), 32'(exp_n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
